// File: rtl/vedic_mult_seq.sv
// Sequential Urdhva-Tiryakbhyam multiplier: 2-bit digits, one crosswise column per clock.
// Handshake: start accepted in IDLE/DONE, busy during CALC, one-cycle done with y held afterwards.
module vedic_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(9 * (WIDTH / 2) + 1) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y
);

  localparam int N  = WIDTH / 2;
  localparam int KW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [KW-1:0]      r_k;
  logic [CW-1:0]      r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_y;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [CW-1:0]      w_col;
  logic [CW-1:0]      w_s;
  logic [CW-1:0]      w_carry_next;
  logic               w_last;
  logic [3:0]         w_prod [N][N];

  // 2x2 vertical-and-crosswise cell built from AND gates and two half adders.
  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] z);
    logic       c1;
    logic [3:0] p;
    p[0] = x[0] & z[0];
    p[1] = (x[1] & z[0]) ^ (x[0] & z[1]);
    c1   = (x[1] & z[0]) & (x[0] & z[1]);
    p[2] = (x[1] & z[1]) ^ c1;
    p[3] = (x[1] & z[1]) & c1;
    return p;
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        assign w_prod[gi][gj] = vedic2x2(r_a[2*gi +: 2], r_b[2*gj +: 2]);
      end
    end
  endgenerate

  // Column k collects every digit pair with i+j == k; out-of-range pairs never match.
  always_comb begin
    w_col = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i + j == int'(r_k)) w_col = w_col + CW'(w_prod[i][j]);
      end
    end
  end

  assign w_s          = w_col + r_carry;
  assign w_carry_next = w_s >> 2;
  assign w_last       = (r_k == KW'(2 * N - 2));

  // Final column also deposits its carry as the top digit so y can load in the same edge.
  always_comb begin
    w_acc_next = r_acc;
    for (int d = 0; d < 2 * N - 1; d++) begin
      if (r_k == KW'(d)) w_acc_next[2*d +: 2] = w_s[1:0];
    end
    if (w_last) w_acc_next[2*WIDTH-1 -: 2] = w_carry_next[1:0];
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = start ? CALC : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_carry <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_k     <= '0;
            r_carry <= '0;
          end
        end
        CALC: begin
          r_acc   <= w_acc_next;
          r_carry <= w_carry_next;
          r_k     <= r_k + 1'b1;
          if (w_last) r_y <= w_acc_next;
        end
        default: ;
      endcase
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed and table-driven checks of vedic_mult_seq at WIDTH 8, plus WIDTH 4 and 16 instances.
module tb_vedic_mult_seq;

  logic clk;
  logic rst8, rst4, rst16;
  logic start8, start4, start16;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic [15:0] a16, b16;
  logic busy8, done8, busy4, done4, busy16, done16;
  logic [15:0] y8;
  logic [7:0]  y4;
  logic [31:0] y16;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_y8 = '0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
  } vec8_t;
  vec8_t tbl [8];

  vedic_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8)
  );
  vedic_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .y(y4)
  );
  vedic_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .y(y16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One WIDTH=8 multiplication: busy count, done latency, held previous y mid-run, result.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] ey, input string nm);
    int busy_cnt;
    int done_at;
    @(negedge clk);
    a8 = ta; b8 = tb; start8 = 1'b1;
    busy_cnt = 0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin start8 = 1'b0; a8 = ~ta; b8 = ~tb; end
      if (c == 4) check({nm, "_hold"}, y8, last_y8);
      if (busy8) busy_cnt++;
      if (done8) begin done_at = c; break; end
    end
    check({nm, "_busy"}, busy_cnt, 7);
    check({nm, "_lat"}, done_at, 8);
    check({nm, "_y"}, y8, ey);
    last_y8 = ey;
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb);
    int done_at;
    @(negedge clk);
    a4 = ta; b4 = tb; start4 = 1'b1;
    done_at = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) begin done_at = c; break; end
    end
    check("w4_lat", done_at, 4);
    check("w4_y", y4, 8'(ta) * 8'(tb));
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb);
    int done_at;
    @(negedge clk);
    a16 = ta; b16 = tb; start16 = 1'b1;
    done_at = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (done16) begin done_at = c; break; end
    end
    check("w16_lat", done_at, 16);
    check("w16_y", y16, 32'(ta) * 32'(tb));
  endtask

  initial begin
    int d1, d2, ndone, bad;
    tbl[0] = '{8'd0,   8'd200, 16'd0};
    tbl[1] = '{8'd1,   8'd173, 16'd173};
    tbl[2] = '{8'd128, 8'd2,   16'd256};
    tbl[3] = '{8'd15,  8'd15,  16'd225};
    tbl[4] = '{8'd170, 8'd85,  16'd14450};
    tbl[5] = '{8'd1,   8'd255, 16'd255};
    tbl[6] = '{8'd254, 8'd253, 16'd64262};
    tbl[7] = '{8'd2,   8'd3,   16'd6};

    rst8 = 1'b1; rst4 = 1'b1; rst16 = 1'b1;
    start8 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_y", y8, 0);
    rst8 = 1'b0; rst4 = 1'b0; rst16 = 1'b0;

    // Full-scale operands, then result must hold through idle cycles.
    op8(8'd255, 8'd255, 16'd65025, "ff_ff");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (y8 !== 16'd65025 || done8 !== 1'b0) bad++;
    end
    check("idle_hold", bad, 0);

    for (int i = 0; i < 8; i++) op8(tbl[i].a, tbl[i].b, tbl[i].y, $sformatf("tbl%0d", i));

    // Start pulse during the third busy cycle must be ignored.
    @(negedge clk);
    a8 = 8'd12; b8 = 8'd13; start8 = 1'b1;
    d1 = 0; ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (c == 3) begin a8 = 8'd99; b8 = 8'd99; start8 = 1'b1; end
      if (c == 4) begin start8 = 1'b0; a8 = '0; b8 = '0; end
      if (done8) begin ndone++; if (d1 == 0) d1 = c; end
      if (c == 8) check("ign_y", y8, 156);
    end
    check("ign_lat", d1, 8);
    check("ign_ndone", ndone, 1);
    check("ign_yhold", y8, 156);

    // Asynchronous reset in the fourth busy cycle.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd150; start8 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    check("abort_pre_busy", busy8, 1);
    check("abort_pre_y", y8, 156);
    #2 rst8 = 1'b1;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_y", y8, 0);
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_nodone", ndone, 0);
    last_y8 = '0;
    op8(8'd3, 8'd7, 16'd21, "post_rst");

    // Start held high: back-to-back products, new operands applied in DONE.
    @(negedge clk);
    a8 = 8'd17; b8 = 8'd19; start8 = 1'b1;
    d1 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done8) begin d1 = c; break; end
    end
    check("b2b_lat1", d1, 8);
    check("b2b_y1", y8, 323);
    a8 = 8'd250; b8 = 8'd3;
    d2 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done8) begin d2 = c; break; end
    end
    start8 = 1'b0;
    check("b2b_lat2", d2, 8);
    check("b2b_y2", y8, 750);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run4(4'(i), 4'(j));

    run16(16'hFFFF, 16'hFFFF);
    run16(16'h0000, 16'hFFFF);
    repeat (1500) run16(16'($urandom()), 16'($urandom()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
